// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared constants for the data-memory arbiter: arbitration
//               state encoding, lock counter width and default segment
//               geometry of the data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    // Arbitration state encoding
    localparam int unsigned        STATE_W = 2;
    localparam logic [STATE_W-1:0] ARB     = 2'd0;  // round-robin between masters
    localparam logic [STATE_W-1:0] LOCK0   = 2'd1;  // master 0 holds the lock
    localparam logic [STATE_W-1:0] LOCK1   = 2'd2;  // master 1 holds the lock

    // Width of the consecutive-locked-grant counter (MAX_LOCK up to 15)
    localparam int unsigned LOCK_CNT_W = 4;

    // Default data segment geometry
    localparam logic [31:0] DEF_DATA_START = 32'h1000_0000;
    localparam logic [31:0] DEF_DATA_WORDS = 32'h0004_0000;

endpackage
`default_nettype wire

// File: rtl/dmem_range_check.sv
`default_nettype none
// ============================================================================
// Module      : dmem_range_check
// Description : Combinational data-segment range check for one byte address.
//               o_in_range = DATA_START <= i_addr < DATA_START + 4*DATA_WORDS.
//               The upper bound is formed in 33 bits so it cannot wrap.
// Ports       : i_addr     - byte address to check
//               o_in_range - address lies inside the data segment
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_range_check
    import dmem_arb_pkg::*;
#(
    parameter logic [31:0] DATA_START = DEF_DATA_START,
    parameter logic [31:0] DATA_WORDS = DEF_DATA_WORDS
) (
    input  logic [31:0] i_addr,
    output logic        o_in_range
);

    localparam logic [32:0] C_LO = {1'b0, DATA_START};
    localparam logic [32:0] C_HI = C_LO + (33'(DATA_WORDS) << 2);

    logic [32:0] w_addr;

    assign w_addr     = {1'b0, i_addr};
    assign o_in_range = (w_addr >= C_LO) && (w_addr < C_HI);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-master arbiter for the single-port data memory.
//               Master 0 is the processor data port, master 1 a secondary
//               requester (DMA / loader). One access per cycle, round-robin
//               priority, bounded lock for read-modify-write sequences,
//               registered read responses and out-of-range error pulses.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               mN_req/write/lock     - request, direction, keep-grant hint
//               mN_addr/wdata         - byte address and write data
//               mN_gnt                - combinational grant
//               mN_rvalid/rdata       - read response, one cycle after grant
//               mN_err                - out-of-range pulse, one cycle after grant
//               mem_*                 - memory addr/data_in/read/write/data_out
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter logic [31:0] DATA_START = DEF_DATA_START,
    parameter logic [31:0] DATA_WORDS = DEF_DATA_WORDS,
    parameter int unsigned MAX_LOCK   = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_write,
    input  logic        m0_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_write,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_data_out
);

    localparam logic [LOCK_CNT_W-1:0] C_LOCK_LAST = LOCK_CNT_W'(MAX_LOCK - 1);

    // Per-master views so both masters share one code path
    logic [1:0]            w_req;
    logic [1:0]            w_wr;
    logic [1:0]            w_lock;
    logic [1:0]            w_in_range;
    logic [31:0]           w_addr [2];
    logic [1:0]            w_gnt;
    logic                  w_sel;

    logic [STATE_W-1:0]    r_state;
    logic [STATE_W-1:0]    w_state_nxt;
    logic [LOCK_CNT_W-1:0] r_lock_cnt;
    logic [LOCK_CNT_W-1:0] w_lock_cnt_nxt;
    logic [LOCK_CNT_W-1:0] w_cnt_base;
    logic                  r_last_gnt;
    logic                  w_last_gnt_nxt;

    logic [1:0]            r_rvalid;
    logic [1:0]            r_err;
    logic [31:0]           r_rdata [2];

    assign w_req     = {m1_req,   m0_req};
    assign w_wr      = {m1_write, m0_write};
    assign w_lock    = {m1_lock,  m0_lock};
    assign w_addr[0] = m0_addr;
    assign w_addr[1] = m1_addr;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_range
            dmem_range_check #(
                .DATA_START (DATA_START),
                .DATA_WORDS (DATA_WORDS)
            ) u_range_check (
                .i_addr     (w_addr[gi]),
                .o_in_range (w_in_range[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Arbitration state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ARB;
            r_lock_cnt <= '0;
            r_last_gnt <= 1'b1;   // master 0 wins the first tie
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_last_gnt <= w_last_gnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Grant selection and next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_gnt          = 2'b00;
        w_state_nxt    = ARB;
        w_lock_cnt_nxt = '0;
        w_last_gnt_nxt = r_last_gnt;
        w_cnt_base     = '0;

        if (!reset) begin
            case (r_state)
                LOCK0: begin
                    if (w_req[0])      w_gnt = 2'b01;
                    else if (w_req[1]) w_gnt = 2'b10;
                end
                LOCK1: begin
                    if (w_req[1])      w_gnt = 2'b10;
                    else if (w_req[0]) w_gnt = 2'b01;
                end
                default: begin
                    if (&w_req) w_gnt = r_last_gnt ? 2'b01 : 2'b10;
                    else        w_gnt = w_req;
                end
            endcase
        end

        w_sel = w_gnt[1];

        // The counter only carries over while the lock holder keeps winning;
        // a grant to the other master starts a fresh lock run.
        if ((r_state == LOCK0 && w_gnt[0]) || (r_state == LOCK1 && w_gnt[1]))
            w_cnt_base = r_lock_cnt;

        if (|w_gnt) begin
            w_last_gnt_nxt = w_sel;
            if (w_lock[w_sel] && (w_cnt_base < C_LOCK_LAST)) begin
                w_state_nxt    = w_sel ? LOCK1 : LOCK0;
                w_lock_cnt_nxt = w_cnt_base + 1'b1;
            end
        end
    end

    assign m0_gnt = w_gnt[0];
    assign m1_gnt = w_gnt[1];

    // ------------------------------------------------------------------------
    // Memory drive: granted master, master 0 when idle. Enables are masked by
    // the range check; grants are already zero while reset is high.
    // ------------------------------------------------------------------------
    assign mem_addr    = w_gnt[1] ? m1_addr  : m0_addr;
    assign mem_data_in = w_gnt[1] ? m1_wdata : m0_wdata;
    assign mem_read    = |(w_gnt & ~w_wr & w_in_range);
    assign mem_write   = |(w_gnt &  w_wr & w_in_range);

    // ------------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rvalid <= 2'b00;
            r_err    <= 2'b00;
            for (int i = 0; i < 2; i++) r_rdata[i] <= '0;
        end else begin
            r_rvalid <= w_gnt & ~w_wr;
            r_err    <= w_gnt & ~w_in_range;
            for (int i = 0; i < 2; i++) begin
                if (w_gnt[i] && !w_wr[i])
                    r_rdata[i] <= w_in_range[i] ? mem_data_out : 32'h0;
            end
        end
    end

    // Masking with reset drops a response whose grant cycle preceded reset.
    assign m0_rvalid = r_rvalid[0] & ~reset;
    assign m1_rvalid = r_rvalid[1] & ~reset;
    assign m0_err    = r_err[0] & ~reset;
    assign m1_err    = r_err[1] & ~reset;
    assign m0_rdata  = reset ? 32'h0 : r_rdata[0];
    assign m1_rdata  = reset ? 32'h0 : r_rdata[1];

endmodule
`default_nettype wire
